// File: rtl/fp16_mul_sched_if.sv
// Bundle of the request, multiplier and response signals of fp16_mul_sched.
// slave is the scheduler's view; master is the view of its surroundings.
interface fp16_mul_sched_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic             mul_start;
    logic [WIDTH-1:0] mul_sum;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  mul_sum, rsp_ready,
        output req0_ready, req1_ready,
        output mul_a, mul_b, mul_start,
        output rsp_valid, rsp_data, rsp_id, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output mul_sum, rsp_ready,
        input  req0_ready, req1_ready,
        input  mul_a, mul_b, mul_start,
        input  rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/fp16_mul_sched.sv
// Shares one external FP16 multiplier between two requesters.
// Round-robin grant, one operation in flight, result returned with requester id.
module fp16_mul_sched #(
    parameter int WIDTH   = 16,
    parameter int MUL_LAT = 1,
    parameter int CNT_W   = 4
) (
    input logic            clk,
    input logic            rst_n,
    fp16_mul_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             rr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             id_q;
    logic [WIDTH-1:0] mul_a_q;
    logic [WIDTH-1:0] mul_b_q;
    logic             mul_start_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_id_q;

    logic             grant;
    logic             any_req;
    logic             issue;
    logic             capture;
    logic             rsp_done;
    logic             req0_ready_c;
    logic             req1_ready_c;

    // Arbitration: a lone valid requester wins, contention is settled by rr_ptr.
    always_comb begin
        any_req = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = rr_ptr_q;
        end else begin
            grant = bus.req1_valid;
        end
    end

    // Next-state and handshake decode; ready is forced low while reset is held.
    always_comb begin
        state_d      = state_q;
        req0_ready_c = 1'b0;
        req1_ready_c = 1'b0;
        issue        = 1'b0;
        capture      = 1'b0;
        rsp_done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req && rst_n) begin
                    req0_ready_c = ~grant;
                    req1_ready_c = grant;
                    issue        = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch, latency counter, result capture and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= 1'b0;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            // Registered handshake gives exactly one pulse in the first EXEC cycle.
            mul_start_q <= issue;
            if (issue) begin
                mul_a_q <= grant ? bus.req1_a : bus.req0_a;
                mul_b_q <= grant ? bus.req1_b : bus.req0_b;
                id_q    <= grant;
                cnt_q   <= CNT_W'(MUL_LAT);
            end
            if (state_q == EXEC && !capture) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (capture) begin
                rsp_data_q <= bus.mul_sum;
                rsp_id_q   <= id_q;
            end
            if (rsp_done) begin
                rr_ptr_q <= ~rsp_id_q;
            end
        end
    end

    assign bus.req0_ready = req0_ready_c;
    assign bus.req1_ready = req1_ready_c;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.mul_start  = mul_start_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.busy       = (state_q != IDLE);

endmodule
